// File: rtl/pixel_canvas.sv
// pixel_canvas: colour-code framebuffer with brush-stamp / clear write FSM
// and an integer-upscaled VGA read path with border fill.
module pixel_canvas #(
  parameter int CANVAS_W    = 256,
  parameter int CANVAS_H    = 128,
  parameter int COLOR_BITS  = 3,
  parameter int SCALE_SHIFT = 1,
  parameter int HACTIVE     = 640,
  parameter int VACTIVE     = 480,
  parameter logic [COLOR_BITS-1:0] BORDER_COLOR = 3'b101,
  parameter logic [COLOR_BITS-1:0] CLEAR_COLOR  = 3'b000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        brush,
  input  logic [1:0]                  brushSize,
  input  logic [COLOR_BITS-1:0]       newColor,
  input  logic [$clog2(CANVAS_W)-1:0] wx,
  input  logic [$clog2(CANVAS_H)-1:0] wy,
  input  logic                        clear,
  input  logic [9:0]                  rx,
  input  logic [9:0]                  ry,
  output logic                        ready,
  output logic [COLOR_BITS-1:0]       colorCode
);

  localparam int XW    = $clog2(CANVAS_W);
  localparam int YW    = $clog2(CANVAS_H);
  localparam int AW    = XW + YW;
  localparam int DEPTH = CANVAS_W * CANVAS_H;

  localparam logic signed [10:0] OFFX =
    11'((HACTIVE - (CANVAS_W << SCALE_SHIFT)) / 2);
  localparam logic signed [10:0] OFFY =
    11'((VACTIVE - (CANVAS_H << SCALE_SHIFT)) / 2);
  localparam logic signed [10:0] SPANX = 11'(CANVAS_W << SCALE_SHIFT);
  localparam logic signed [10:0] SPANY = 11'(CANVAS_H << SCALE_SHIFT);
  localparam logic [AW-1:0]      LAST  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

  state_t                r_state;
  state_t                w_state_n;
  logic [AW-1:0]         r_cnt;
  logic [1:0]            r_dx;
  logic [1:0]            r_dy;
  logic [1:0]            r_side;
  logic [XW-1:0]         r_x0;
  logic [YW-1:0]         r_y0;
  logic [COLOR_BITS-1:0] r_col;
  logic                  r_pend;

  logic [XW:0]           w_px;
  logic [YW:0]           w_py;
  logic                  w_take;
  logic                  w_we;
  logic                  w_wr;
  logic [AW-1:0]         w_waddr;
  logic [COLOR_BITS-1:0] w_wdata;

  assign w_px   = {1'b0, r_x0} + (XW+1)'(r_dx);
  assign w_py   = {1'b0, r_y0} + (YW+1)'(r_dy);
  assign w_take = brush & ~clear & ~r_pend;
  assign w_wr   = w_we & ~reset;
  assign ready  = (r_state == IDLE);

  always_comb begin
    w_state_n = r_state;
    w_we      = 1'b0;
    w_waddr   = '0;
    w_wdata   = CLEAR_COLOR;
    unique case (r_state)
      IDLE: begin
        if (r_pend | clear)
          w_state_n = CLEAR;
        else if (brush)
          w_state_n = PAINT;
      end
      PAINT: begin
        // carry bit set means the pixel fell off the canvas edge
        w_we    = ~w_px[XW] & ~w_py[YW];
        w_waddr = {w_py[YW-1:0], w_px[XW-1:0]};
        w_wdata = r_col;
        if (r_dx == r_side && r_dy == r_side)
          w_state_n = IDLE;
      end
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        if (r_cnt == LAST)
          w_state_n = IDLE;
      end
      default: w_state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_side  <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_n;
      if (r_state == IDLE)
        r_pend <= 1'b0;
      else if (clear)
        r_pend <= 1'b1;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_dx  <= '0;
          r_dy  <= '0;
          if (w_take) begin
            r_x0   <= wx;
            r_y0   <= wy;
            r_col  <= newColor;
            r_side <= brushSize;
          end
        end
        PAINT: begin
          if (r_dx == r_side) begin
            r_dx <= '0;
            r_dy <= r_dy + 2'd1;
          end else begin
            r_dx <= r_dx + 2'd1;
          end
        end
        CLEAR: r_cnt <= r_cnt + AW'(1);
        default: ;
      endcase
    end
  end

  logic [COLOR_BITS-1:0] r_mem [DEPTH];
  logic [COLOR_BITS-1:0] r_rdata;
  logic signed [10:0]    w_cx;
  logic signed [10:0]    w_cy;
  logic                  w_inside;
  logic [AW-1:0]         w_raddr;

  assign w_cx     = $signed({1'b0, rx}) - OFFX;
  assign w_cy     = $signed({1'b0, ry}) - OFFY;
  assign w_inside = ~w_cx[10] & (w_cx < SPANX) &
                    ~w_cy[10] & (w_cy < SPANY);
  assign w_raddr  = {w_cy[SCALE_SHIFT +: YW], w_cx[SCALE_SHIFT +: XW]};

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[w_waddr] <= w_wdata;
    r_rdata <= r_mem[w_raddr];
  end

  logic r_v1;
  logic r_in1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_in1     <= 1'b0;
      colorCode <= CLEAR_COLOR;
    end else begin
      r_v1  <= 1'b1;
      r_in1 <= w_inside;
      if (r_v1)
        colorCode <= r_in1 ? r_rdata : BORDER_COLOR;
    end
  end

endmodule

// File: tb/tb_pixel_canvas.sv
// tb_pixel_canvas: table vectors, hand sequences and random stamps/reads
// checked against an array model of the canvas.
module tb_pixel_canvas;

  localparam int CW     = 256;
  localparam int CH     = 32;
  localparam int SC     = 2;
  localparam int OFFX   = (640 - CW * SC) / 2;
  localparam int OFFY   = (480 - CH * SC) / 2;
  localparam int NPIX   = CW * CH;
  localparam int BORDER = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       brush = 1'b0;
  logic [1:0] brushSize = '0;
  logic [2:0] newColor = '0;
  logic [7:0] wx = '0;
  logic [4:0] wy = '0;
  logic       clear = 1'b0;
  logic [9:0] rx = '0;
  logic [9:0] ry = '0;
  logic       ready;
  logic [2:0] colorCode;

  pixel_canvas #(.CANVAS_W(CW), .CANVAS_H(CH)) dut (
    .clk(clk), .reset(reset), .brush(brush), .brushSize(brushSize),
    .newColor(newColor), .wx(wx), .wy(wy), .clear(clear),
    .rx(rx), .ry(ry), .ready(ready), .colorCode(colorCode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2:0] model [NPIX];

  typedef struct {
    string nm;
    int    rx;
    int    ry;
    int    exp;
  } rv_t;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_color(input int x, input int y);
    int cx, cy;
    cx = x - OFFX;
    cy = y - OFFY;
    if (cx < 0 || cx >= CW * SC || cy < 0 || cy >= CH * SC)
      return BORDER;
    return int'(model[(cy / SC) * CW + cx / SC]);
  endfunction

  task automatic model_clear();
    foreach (model[i]) model[i] = 3'd0;
  endtask

  task automatic model_stamp(input int sz, input int x0,
                             input int y0, input int col);
    for (int dy = 0; dy <= sz; dy++)
      for (int dx = 0; dx <= sz; dx++)
        if (x0 + dx < CW && y0 + dy < CH)
          model[(y0 + dy) * CW + x0 + dx] = 3'(col);
  endtask

  task automatic wait_ready(output int n, input int limit);
    n = 0;
    while (!ready && n < limit) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic rd_check(input string nm, input int x, input int y,
                          input int e);
    rx = 10'(x);
    ry = 10'(y);
    repeat (2) @(posedge clk);
    #1;
    check(nm, int'(colorCode), e);
  endtask

  task automatic do_stamp(input int sz, input int x, input int y,
                          input int col, input string nm);
    int n;
    check({nm, "_rdy"}, int'(ready), 1);
    brush = 1'b1;
    brushSize = 2'(sz);
    wx = 8'(x);
    wy = 5'(y);
    newColor = 3'(col);
    @(posedge clk); #1;
    brush = 1'b0;
    wait_ready(n, 100);
    check({nm, "_busy"}, n, (sz + 1) * (sz + 1));
    model_stamp(sz, x, y, col);
  endtask

  initial begin
    rv_t t0 [7];
    rv_t t1 [14];
    logic [2:0] q [$];
    int n, px, py, x, y, old;

    t0[0] = '{"rst_left",   OFFX - 1,       OFFY + 10,      BORDER};
    t0[1] = '{"rst_right",  OFFX + CW * SC, OFFY + 10,      BORDER};
    t0[2] = '{"rst_top",    100,            OFFY - 1,       BORDER};
    t0[3] = '{"rst_bottom", 100,            OFFY + CH * SC, BORDER};
    t0[4] = '{"rst_origin", OFFX,           OFFY,           0};
    t0[5] = '{"rst_far",    OFFX + CW*SC-1, OFFY + CH*SC-1, 0};
    t0[6] = '{"rst_mid",    300,            250,            0};

    t1[0]  = '{"st_p0",     OFFX + 20,  OFFY + 40, 3};
    t1[1]  = '{"st_p3",     OFFX + 23,  OFFY + 43, 3};
    t1[2]  = '{"st_right",  OFFX + 24,  OFFY + 40, 0};
    t1[3]  = '{"st_below",  OFFX + 20,  OFFY + 44, 0};
    t1[4]  = '{"clip_in0",  OFFX + 508, OFFY + 60, 6};
    t1[5]  = '{"clip_in3",  OFFX + 511, OFFY + 63, 6};
    t1[6]  = '{"clip_nowx", OFFX,       OFFY + 60, 0};
    t1[7]  = '{"clip_nwx1", OFFX + 2,   OFFY + 60, 0};
    t1[8]  = '{"clip_nowy", OFFX + 508, OFFY,      0};
    t1[9]  = '{"corner0",   OFFX,       OFFY,      2};
    t1[10] = '{"corner1",   OFFX + 1,   OFFY + 1,  2};
    t1[11] = '{"corner_nx", OFFX + 2,   OFFY,      0};
    t1[12] = '{"corner_bl", OFFX - 1,   OFFY,      BORDER};
    t1[13] = '{"corner_bt", OFFX,       OFFY - 1,  BORDER};

    model_clear();

    // reset and initial sweep
    repeat (3) @(posedge clk);
    #1;
    check("rst_color", int'(colorCode), 0);
    check("rst_ready", int'(ready), 0);
    reset = 1'b0;
    wait_ready(n, NPIX + 100);
    check("init_busy", n, NPIX);
    foreach (t0[i]) rd_check(t0[i].nm, t0[i].rx, t0[i].ry, t0[i].exp);

    // directed stamps
    do_stamp(1, 10, 20, 3, "st");
    do_stamp(3, 254, 30, 6, "clip");
    do_stamp(0, 0, 0, 2, "corner");
    foreach (t1[i]) rd_check(t1[i].nm, t1[i].rx, t1[i].ry, t1[i].exp);

    // random stamps near both x edges, then pipelined random reads
    for (int k = 0; k < 30; k++) begin
      x = ($urandom % 2) ? $urandom_range(0, 15) : $urandom_range(240, 255);
      do_stamp($urandom_range(0, 3), x, $urandom_range(0, CH - 1),
               $urandom_range(0, 7), "rnd_st");
    end
    for (int k = 0; k < 302; k++) begin
      if (k >= 2) check("rnd_rd", int'(colorCode), int'(q.pop_front()));
      if (k < 300) begin
        if ($urandom % 4 == 0) begin
          x = $urandom_range(0, 1023);
          y = $urandom_range(0, 1023);
        end else begin
          px = ($urandom % 2) ? $urandom_range(0, 18)
                              : $urandom_range(237, 255);
          py = $urandom_range(0, CH - 1);
          x = OFFX + px * SC + $urandom_range(0, SC - 1);
          y = OFFY + py * SC + $urandom_range(0, SC - 1);
        end
        rx = 10'(x);
        ry = 10'(y);
        q.push_back(3'(exp_color(x, y)));
      end
      @(posedge clk); #1;
    end

    // brush and clear together in IDLE: clear wins, brush dropped
    old = exp_color(OFFX + 20, OFFY + 40);
    brush = 1'b1;
    clear = 1'b1;
    brushSize = 2'd0;
    wx = 8'd10;
    wy = 5'd20;
    newColor = 3'd6;
    @(posedge clk); #1;
    brush = 1'b0;
    clear = 1'b0;
    n = 0;
    while (!ready && n < NPIX + 100) begin
      if (n == 2) begin
        rx = 10'(OFFX + 20);
        ry = 10'(OFFY + 40);
      end
      if (n == 4) check("bc_nopaint", int'(colorCode), old);
      n++;
      @(posedge clk); #1;
    end
    check("bc_busy", n, NPIX);
    model_clear();
    rd_check("bc_cleared", OFFX + 508, OFFY + 60, 0);

    // clear pulse mid-stamp, brush pulse while busy
    check("mc_rdy", int'(ready), 1);
    brush = 1'b1;
    brushSize = 2'd3;
    wx = 8'd0;
    wy = 5'd0;
    newColor = 3'd7;
    @(posedge clk); #1;
    brush = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      if (n == 5) clear = 1'b1;
      if (n == 6) clear = 1'b0;
      if (n == 8) begin
        brush = 1'b1;
        brushSize = 2'd0;
        wx = 8'd50;
        wy = 5'd5;
        newColor = 3'd4;
      end
      if (n == 9) brush = 1'b0;
      n++;
      @(posedge clk); #1;
    end
    check("mc_stamp_busy", n, 16);
    @(posedge clk); #1;
    check("mc_clear_start", int'(ready), 0);
    n = 0;
    while (!ready && n < NPIX + 100) begin
      if (n == 2) begin
        rx = 10'(OFFX + 6);
        ry = 10'(OFFY + 6);
      end
      if (n == 4) begin
        check("mc_stamp_done", int'(colorCode), 7);
        rx = 10'(OFFX);
        ry = 10'(OFFY);
      end
      if (n == 6) check("mc_swept0", int'(colorCode), 0);
      n++;
      @(posedge clk); #1;
    end
    check("mc_clear_busy", n, NPIX);
    model_clear();
    rd_check("mc_no_queue", OFFX + 100, OFFY + 10, 0);

    // reset mid-stamp
    rd_check("rs_pre_border", 0, 0, BORDER);
    brush = 1'b1;
    brushSize = 2'd3;
    wx = 8'd100;
    wy = 5'd10;
    newColor = 3'd5;
    @(posedge clk); #1;
    brush = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rs_in_stamp", int'(ready), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rs_ready", int'(ready), 0);
    check("rs_color", int'(colorCode), 0);
    reset = 1'b0;
    wait_ready(n, NPIX + 100);
    check("rs_busy", n, NPIX);
    rd_check("rs_stamp_gone", OFFX + 200, OFFY + 20, 0);
    rd_check("rs_border", OFFX - 1, OFFY, BORDER);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_canvas.md
# pixel_canvas

Parametrised framebuffer for the VGA painting path. It stores a CANVAS_W × CANVAS_H grid of colour codes. A write-side FSM paints square brush stamps and performs full-canvas clears. The read side maps VGA raster coordinates into the canvas with integer upscaling and returns the border colour outside it. It sits between the brush/cursor logic and the VGA colour decoder, replacing the fixed-size single-pixel store.

## Interface
- CANVAS_W, 256, canvas width in pixels; power of two
- CANVAS_H, 128, canvas height in pixels; power of two
- COLOR_BITS, 3, bits per colour code
- SCALE_SHIFT, 1, display scale is 2^SCALE_SHIFT screen pixels per canvas pixel in each axis
- HACTIVE, 640, visible raster width
- VACTIVE, 480, visible raster height
- BORDER_COLOR, 3'b101, colour returned outside the canvas (purple)
- CLEAR_COLOR, 3'b000, colour written by a clear
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- brush  in  1  stamp request; accepted when brush & ready & ~clear
- brushSize  in  2  stamp side length minus 1 (side 1..4 pixels)
- newColor  in  COLOR_BITS  stamp colour
- wx  in  log2(CANVAS_W)  stamp top-left x
- wy  in  log2(CANVAS_H)  stamp top-left y
- clear  in  1  single-cycle clear request
- rx  in  10  raster x
- ry  in  10  raster y
- ready  out  1  write FSM idle and able to accept a stamp
- colorCode  out  COLOR_BITS  pixel colour for (rx, ry), 2-cycle latency

## Operation
- Storage: internal inferred RAM with CANVAS_W*CANVAS_H entries of COLOR_BITS. Address is {y, x}. There is one write port and one synchronous read port. Same-address read/write in one cycle returns the old data.
- Write FSM states:
  - IDLE: ready=1.
  - PAINT: stamp in progress, ready=0.
  - CLEAR: sweep in progress, ready=0.
- Transitions from IDLE:
  - If clearPending or clear is set, go to CLEAR with the counter at 0.
  - Otherwise, if brush is set, latch x0=wx, y0=wy, colour, and side S=brushSize+1, then go to PAINT.
- PAINT:
  - Performs one write per cycle, row-major: dx=0..S-1 inner, dy=0..S-1 outer, writing pixel (x0+dx, y0+dy).
  - Sums are computed one bit wider than the coordinate. A pixel with x ≥ CANVAS_W or y ≥ CANVAS_H is clipped: the cycle is spent but the write is suppressed. There is no wrap-around.
  - After S² cycles, return to IDLE.
- CLEAR:
  - Writes CLEAR_COLOR to addresses 0..CANVAS_W*CANVAS_H-1, one per cycle.
  - Returns to IDLE after the last address.
  - clearPending is cleared on entry.
- clearPending: set by clear in any non-IDLE state. Serviced on the next return to IDLE, before any stamp. Multiple clear pulses collapse into one.
- Simultaneous clear and brush in IDLE: clear wins and the brush is not accepted. brush is ignored whenever ready=0; no queueing.
- Reset:
  - state=CLEAR with counter 0, so the canvas is initialised to CLEAR_COLOR.
  - ready=0, clearPending=0, colorCode=CLEAR_COLOR, read pipeline valid flags=0.
  - Reset mid-PAINT or mid-CLEAR abandons the operation and restarts the clear sweep.
- Read mapping, computed in 11-bit signed arithmetic:
  - offX=(HACTIVE−(CANVAS_W<<SCALE_SHIFT))/2; offY=(VACTIVE−(CANVAS_H<<SCALE_SHIFT))/2.
  - cx=rx−offX; cy=ry−offY.
  - inside = cx ≥ 0 & cx < CANVAS_W<<SCALE_SHIFT & cy ≥ 0 & cy < CANVAS_H<<SCALE_SHIFT.
  - Read address = {cy>>SCALE_SHIFT, cx>>SCALE_SHIFT}, truncated to the address width.
  - Negative offsets are not supported; the canvas must fit the raster.

## Timing
- Read: cycle 0 presents rx/ry. Cycle 1: RAM data available and inside registered. Cycle 2: colorCode = inside ? data : BORDER_COLOR. Throughput is one pixel per cycle.
- Stamp: accepted at edge N, so ready=0 from N+1. The first write occurs in cycle N+1. ready=1 again at N+1+S².
- Clear: CANVAS_W*CANVAS_H write cycles, which is 32768 at defaults. ready rises the cycle after the last write.
- After reset deasserts, ready rises after exactly CANVAS_W*CANVAS_H cycles.
- Reads are unaffected by write activity apart from the read-old-data rule.

## Test plan
- Reset → ready low for 32768 cycles, then high. Every in-canvas read returns 3'b000.
- Read mapping at defaults (offX=64, offY=112):
  - rx=63, ry=200 → 3'b101.
  - rx=576 → 3'b101.
  - ry=111 or ry=368 → 3'b101.
  - rx=64, ry=112 reads pixel (0,0).
  - rx=575, ry=367 reads pixel (255,127). All with 2-cycle latency.
- Stamp brushSize=1, wx=10, wy=20, newColor=3'b011 → ready low for 4 cycles. Pixels (10..11, 20..21)=3'b011 and (12,20) unchanged. Raster (84,152) and (87,155) read 3'b011.
- Clipping stamp brushSize=3, wx=254, wy=126, colour 3'b110 → 16 busy cycles. Only (254..255, 126..127) are written. Pixels (0,126) and (254,0) are unchanged.
- clear asserted mid-stamp → the stamp completes, then a clear starts immediately. Simultaneous brush+clear in IDLE → clear runs and the brush is dropped.
- Reset asserted mid-stamp → the stamp is aborted, ready=0, colorCode=3'b000 next cycle, and a full clear sweep follows.
